// File: rtl/mul_pkg.sv
// Shared definitions for the sequential multiplier: state encoding and default operand width.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mul_pkg;

    // Default operand width; the product is twice this wide.
    localparam int MUL_WIDTH = 32;

    // Controller states: waiting, iterating over multiplier bits, presenting a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/add_carry.sv
// WIDTH-bit unsigned adder with carry out, used for the partial-product accumulate.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module add_carry #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Zero-extend both operands so the carry lands in the extra top bit.
    always_comb begin
        {cout, sum} = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/mul_seq.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// Latency: result and done pulse WIDTH+1 cycles after start is accepted.
// Backpressure: start is ignored while busy; no queuing, one result per WIDTH+1 cycles back-to-back.
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic [WIDTH-1:0]   hi_q,      hi_d;
    logic [WIDTH-1:0]   lo_q,      lo_d;
    logic [CW-1:0]      cnt_q,     cnt_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     partial;

    // hi + captured multiplicand; only selected when the current multiplier bit is set.
    add_carry #(
        .WIDTH (WIDTH)
    ) u_add (
        .a    (hi_q),
        .b    (a_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Next-state logic: accept, iterate one multiplier bit, and load the product on the final shift.
    // The adder's carry is shifted straight into hi's MSB, so after every shift the
    // carry position above hi is zero and needs no flop of its own.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        partial   = lo_q[0] ? {add_cout, add_sum} : {1'b0, hi_q};

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    hi_d    = '0;
                    lo_d    = b;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                hi_d  = partial[WIDTH:1];
                lo_d  = {partial[0], lo_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d   = DONE;
                    product_d = {hi_d, lo_d};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset taking priority over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width in bits (≥2).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request a multiply; sampled only while busy=0.
REQ-005 SHALL have port: a  input  WIDTH  multiplicand, unsigned.
REQ-006 SHALL have port: b  input  WIDTH  multiplier, unsigned.
REQ-007 SHALL have port: busy  output  1  operation in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse; product valid.
REQ-009 SHALL have port: product  output  2*WIDTH  registered result.

Function
REQ-010 SHALL implement an iterative unsigned shift-add multiply, one multiplier bit per cycle.
REQ-011 SHALL use three states: IDLE, RUN, DONE.
REQ-012 SHALL accept start=1 in IDLE or DONE, capturing a and b into internal registers on that edge (cycle t).
REQ-013 SHALL initialise working registers on acceptance: carry=0, hi=0, lo=b, cnt=0, and SHALL move to RUN.
REQ-014 SHALL, in each RUN cycle, form {c,s}=hi+A (WIDTH+1 bits) when lo[0]=1, else {0,hi}, then set {carry,hi,lo} to {c,s,lo} shifted right by 1, and increment cnt.
REQ-015 SHALL leave RUN after exactly WIDTH iterations (cnt=WIDTH-1 on the last) and enter DONE.
REQ-016 SHALL drive busy=1 for cycles t+1..t+WIDTH, and 0 otherwise.
REQ-017 SHALL drive done=1 only in cycle t+WIDTH+1 (DONE state); product={hi,lo} is loaded on the same edge.
REQ-018 SHALL hold product unchanged from done until the next completed operation, including during RUN.
REQ-019 SHALL ignore start while busy=1; no queuing.
REQ-020 SHALL return DONE→IDLE if start=0 and DONE→RUN (new operation, REQ-012/013) if start=1, giving back-to-back throughput of one result per WIDTH+1 cycles.
REQ-021 SHALL ignore changes on a and b after capture.
REQ-022 SHALL produce the exact 2*WIDTH-bit product for all operands; no overflow is possible, and the carry bit SHALL be discarded only after the final shift.

Reset
REQ-023 SHALL, with rst=1 at a clock edge, force state=IDLE, busy=0, done=0, product=0, cnt=0, and clear working registers.
REQ-024 SHALL give rst priority over start on the same edge.
REQ-025 SHALL abort an in-flight operation on reset mid-RUN: no done pulse, and product=0.

Structure
REQ-026 SHALL place the state encoding (IDLE/RUN/DONE) and the default WIDTH constant in a shared package, mul_pkg.
REQ-027 SHALL isolate the WIDTH-bit add-with-carry in one sub-module, add_carry (ports a, b, sum, cout; combinational), instanced once.
REQ-028 SHALL size cnt as $clog2(WIDTH) bits.

Verification
REQ-029 SHALL cover: a=3, b=5, start pulse at cycle t -> busy cycles t+1..t+32, done at t+33, product=0x0000_0000_0000_000F.
REQ-030 SHALL cover: a=b=0xFFFF_FFFF -> product=0xFFFF_FFFE_0000_0001; carry path exercised.
REQ-031 SHALL cover: a=0x1234_5678, b=0, then a=0, b=0xDEAD_BEEF -> both products 0, done once each.
REQ-032 SHALL cover: start held high continuously with a=7, b=6 -> done every 33 cycles, product=42 each time; a/b toggled mid-RUN do not alter the result.
REQ-033 SHALL cover: rst=1 at the 10th RUN cycle -> next cycle busy=0, done=0, product=0; a following start with a=2, b=9 yields 18.
REQ-034 SHALL cover: 256 random operand pairs checked against a*b with 64-bit compare; zero mismatches.
